// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one fixed-latency divider among NREQ requesters.
// Request-to-response latency is DIV_LAT+3 cycles; req is only looked at in IDLE.
module divider_arbiter #(
    parameter int NREQ    = 2,
    parameter int DIV_LAT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*10-1:0]   a_in,
    input  logic [NREQ*5-1:0]    d_in,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [5:0]           rsp_quo,
    output logic [5:0]           rsp_rem,
    output logic                 rsp_divby0,
    output logic                 rsp_ovf,
    output logic                 div_start,
    output logic                 div_finish,
    output logic [9:0]           div_ain,
    output logic [4:0]           div_din,
    input  logic [5:0]           div_quo,
    input  logic [5:0]           div_rem,
    input  logic                 div_divby0,
    input  logic                 div_overflow
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    logic [2:0]    r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_owner;
    logic [CW-1:0] r_cnt;
    logic [9:0]    r_ain;
    logic [4:0]    r_din;
    logic [5:0]    r_quo;
    logic [5:0]    r_rem;
    logic          r_divby0;
    logic          r_ovf;

    logic          w_any;
    logic          w_hi_found;
    logic [PW-1:0] w_hi_idx;
    logic [PW-1:0] w_lo_idx;
    logic [PW-1:0] w_win;
    logic [PW-1:0] w_ptr_nxt;
    logic [9:0]    w_a;
    logic [4:0]    w_d;

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_idx = PW'(i);
                if (i >= int'(r_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = PW'(i);
                end
            end
        end
        w_win = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    assign w_any     = |req;
    assign w_ptr_nxt = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_a = '0;
        w_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == PW'(i)) begin
                w_a = a_in[i*10 +: 10];
                w_d = d_in[i*5 +: 5];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_ain    <= '0;
            r_din    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_divby0 <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ain   <= w_a;
                        r_din   <= w_d;
                        r_owner <= w_win;
                        r_ptr   <= w_ptr_nxt;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_cnt   <= CW'(DIV_LAT - 1);
                    r_state <= S_WAIT;
                end
                // The divider has no done flag, so its result is trusted after DIV_LAT WAIT cycles.
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_quo    <= div_quo;
                    r_rem    <= div_rem;
                    r_divby0 <= div_divby0;
                    r_ovf    <= div_overflow;
                    r_state  <= S_FINISH;
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        gnt       = '0;
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i]       = (r_state == S_START)  && (r_owner == PW'(i));
            rsp_valid[i] = (r_state == S_FINISH) && (r_owner == PW'(i));
        end
    end

    assign div_start  = (r_state == S_START);
    assign div_finish = (r_state == S_FINISH);
    assign div_ain    = r_ain;
    assign div_din    = r_din;
    assign rsp_quo    = r_quo;
    assign rsp_rem    = r_rem;
    assign rsp_divby0 = r_divby0;
    assign rsp_ovf    = r_ovf;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed table, multi-cycle sequences, random traffic vs a schedule model.
module tb_divider_arbiter;

    localparam int NREQ    = 2;
    localparam int DIV_LAT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*10-1:0] a_in;
    logic [NREQ*5-1:0] d_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [5:0]        rsp_quo;
    logic [5:0]        rsp_rem;
    logic              rsp_divby0;
    logic              rsp_ovf;
    logic              div_start;
    logic              div_finish;
    logic [9:0]        div_ain;
    logic [4:0]        div_din;
    logic [5:0]        div_quo;
    logic [5:0]        div_rem;
    logic              div_divby0;
    logic              div_overflow;

    always #5 clk = ~clk;

    divider_arbiter #(.NREQ(NREQ), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .d_in(d_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_quo(rsp_quo), .rsp_rem(rsp_rem),
        .rsp_divby0(rsp_divby0), .rsp_ovf(rsp_ovf), .div_start(div_start),
        .div_finish(div_finish), .div_ain(div_ain), .div_din(div_din),
        .div_quo(div_quo), .div_rem(div_rem), .div_divby0(div_divby0),
        .div_overflow(div_overflow)
    );

    typedef struct packed {
        logic [5:0] q;
        logic [5:0] r;
        logic       dz;
        logic       ov;
    } res_t;

    function automatic res_t div_ref(input logic [9:0] a, input logic [4:0] d);
        res_t x;
        int   qi;
        x = '0;
        if (d == 5'd0) begin
            x.dz = 1'b1;
        end else begin
            qi   = int'(a) / int'(d);
            x.q  = 6'(qi);
            x.r  = 6'(int'(a) % int'(d));
            x.ov = (qi > 63);
        end
        return x;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] o;
        o    = '0;
        o[i] = 1'b1;
        return o;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Divider stand-in: outputs are junk until DIV_LAT cycles after start, then hold until finish.
    int   dcnt = 0;
    res_t dres;
    always @(posedge clk) begin
        if (!rst || div_finish) dcnt <= 0;
        else if (div_start) dcnt <= 1;
        else if (dcnt != 0 && dcnt < 1000) dcnt <= dcnt + 1;
    end
    always_comb begin
        dres = div_ref(div_ain, div_din);
        if (dcnt < DIV_LAT + 1) dres = {6'h15, 6'h2A, 1'b1, 1'b1};
    end
    assign div_quo      = dres.q;
    assign div_rem      = dres.r;
    assign div_divby0   = dres.dz;
    assign div_overflow = dres.ov;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            tick;
            if (gnt != '0) ok = 1'b1;
        end
        chk({name, " gnt arrives"}, ok, 1);
    endtask

    task automatic wait_rsp(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            tick;
            if (rsp_valid != '0) ok = 1'b1;
        end
        chk({name, " rsp arrives"}, ok, 1);
    endtask

    // Schedule model: once free, sample req, pick round-robin, then events at fixed offsets.
    bit              mon_en = 1'b0;
    int              m_ptr = 0, m_free = 0, m_owner = 0;
    int              m_gnt_cyc = -1, m_rsp_cyc = -1;
    logic [9:0]      m_a = '0;
    logic [4:0]      m_d = '0;
    res_t            m_res = '0, m_hold = '0;
    logic [NREQ-1:0] mon_eg, mon_er;
    int              n_gnt = 0, n_start = 0, n_fin = 0, n_rsp = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_eg = (cyc == m_gnt_cyc) ? onehot(m_owner) : '0;
            mon_er = (cyc == m_rsp_cyc) ? onehot(m_owner) : '0;
            if (cyc == m_rsp_cyc) m_hold = m_res;
            chk("mon gnt",        gnt,        mon_eg);
            chk("mon div_start",  div_start,  cyc == m_gnt_cyc);
            chk("mon rsp_valid",  rsp_valid,  mon_er);
            chk("mon div_finish", div_finish, cyc == m_rsp_cyc);
            chk("mon div_ain",    div_ain,    m_a);
            chk("mon div_din",    div_din,    m_d);
            chk("mon rsp_quo",    rsp_quo,    m_hold.q);
            chk("mon rsp_rem",    rsp_rem,    m_hold.r);
            chk("mon rsp_divby0", rsp_divby0, m_hold.dz);
            chk("mon rsp_ovf",    rsp_ovf,    m_hold.ov);
            n_gnt   += (gnt != '0) ? 1 : 0;
            n_start += div_start ? 1 : 0;
            n_fin   += div_finish ? 1 : 0;
            n_rsp   += (rsp_valid != '0) ? 1 : 0;
            if (!rst) begin
                m_ptr = 0; m_free = cyc + 1; m_gnt_cyc = -1; m_rsp_cyc = -1;
                m_a = '0; m_d = '0; m_hold = '0;
            end else if (cyc >= m_free && req != '0) begin
                m_owner   = rr_pick(m_ptr, req);
                m_a       = a_in[m_owner*10 +: 10];
                m_d       = d_in[m_owner*5 +: 5];
                m_res     = div_ref(m_a, m_d);
                m_gnt_cyc = cyc + 1;
                m_rsp_cyc = cyc + DIV_LAT + 3;
                m_free    = cyc + DIV_LAT + 4;
                m_ptr     = (m_owner + 1) % NREQ;
            end
        end
    end

    typedef struct {
        string      name;
        int         lane;
        logic [9:0] a;
        logic [4:0] d;
        logic [5:0] q;
        logic [5:0] r;
        logic       dz;
        logic       ov;
    } vec_t;

    function automatic vec_t mk(input string n, input int l, input int a, input int d,
                                input int q, input int r, input int dz, input int ov);
        vec_t v;
        v.name = n; v.lane = l; v.a = 10'(a); v.d = 5'(d);
        v.q = 6'(q); v.r = 6'(r); v.dz = 1'(dz); v.ov = 1'(ov);
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int tg;
        req = '0;
        a_in[v.lane*10 +: 10] = v.a;
        d_in[v.lane*5 +: 5]   = v.d;
        req[v.lane] = 1'b1;
        wait_gnt(v.name);
        tg = cyc;
        chk({v.name, " gnt"}, gnt, onehot(v.lane));
        req = '0;
        wait_rsp(v.name);
        chk({v.name, " rsp_valid"}, rsp_valid, onehot(v.lane));
        chk({v.name, " gnt-to-rsp"}, cyc - tg, DIV_LAT + 2);
        chk({v.name, " divby0"}, rsp_divby0, v.dz);
        chk({v.name, " ovf"}, rsp_ovf, v.ov);
        if (!v.dz && !v.ov) begin
            chk({v.name, " quo"}, rsp_quo, v.q);
            chk({v.name, " rem"}, rsp_rem, v.r);
        end
    endtask

    vec_t            vecs[8];
    int              tprev;
    int              nbad;
    logic [NREQ-1:0] exp_g;

    initial begin
        vecs[0] = mk("basic",    0,  100,  7, 14,  2, 0, 0);
        vecs[1] = mk("divby0",   1,   55,  0,  0,  0, 1, 0);
        vecs[2] = mk("overflow", 0, 1000,  3,  0,  0, 0, 1);
        vecs[3] = mk("max quo",  1,   63,  1, 63,  0, 0, 0);
        vecs[4] = mk("quo 64",   0,   64,  1,  0,  0, 0, 1);
        vecs[5] = mk("max ops",  1, 1023, 31, 33,  0, 0, 0);
        vecs[6] = mk("zero a",   0,    0,  5,  0,  0, 0, 0);
        vecs[7] = mk("max rem",  1,   30, 31,  0, 30, 0, 0);

        rst = 1'b0; req = '0; a_in = '0; d_in = '0;
        tick; tick;
        mon_en = 1'b1;
        chk("reset gnt", gnt, 0);
        chk("reset div_ain", div_ain, 0);
        tick;
        rst = 1'b1;

        for (int v = 0; v < 8; v++) run_vec(vecs[v]);

        // Both requesters high straight out of reset: strict alternation at minimum spacing.
        rst = 1'b0;
        a_in = {10'd77, 10'd200};
        d_in = {5'd5, 5'd9};
        req = 2'b11;
        tick; tick;
        rst = 1'b1;
        tprev = 0;
        for (int g = 0; g < 4; g++) begin
            wait_gnt("contention");
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
            chk("contention order", gnt, exp_g);
            if (g > 0) chk("contention spacing", cyc - tprev, DIV_LAT + 4);
            tprev = cyc;
        end
        req = '0;
        wait_rsp("contention");
        chk("contention last owner", rsp_valid, 2'b10);
        chk("contention last quo", rsp_quo, 15);

        // Reset while the divider is busy: operation vanishes, pointer returns to 0.
        a_in[9:0] = 10'd100;
        d_in[4:0] = 5'd7;
        req = 2'b01;
        wait_gnt("abort");
        chk("abort gnt", gnt, 2'b01);
        req = '0;
        repeat (4) tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        chk("post-reset gnt", gnt, 0);
        chk("post-reset rsp_valid", rsp_valid, 0);
        chk("post-reset rsp_quo", rsp_quo, 0);
        chk("post-reset rsp_rem", rsp_rem, 0);
        chk("post-reset divby0", rsp_divby0, 0);
        chk("post-reset ovf", rsp_ovf, 0);
        chk("post-reset div_start", div_start, 0);
        chk("post-reset div_finish", div_finish, 0);
        chk("post-reset div_ain", div_ain, 0);
        chk("post-reset div_din", div_din, 0);
        nbad = 0;
        repeat (16) begin
            tick;
            if (rsp_valid != '0 || div_finish) nbad++;
        end
        chk("aborted op stays silent", nbad, 0);
        a_in = {10'd90, 10'd45};
        d_in = {5'd9, 5'd4};
        req = 2'b11;
        wait_gnt("after reset");
        chk("after reset ptr 0 wins", gnt, 2'b01);
        req[0] = 1'b0;
        wait_gnt("after reset second");
        chk("after reset second owner", gnt, 2'b10);
        req = '0;
        wait_rsp("after reset");
        chk("after reset quo", rsp_quo, 10);
        tick;

        n_gnt = 0; n_start = 0; n_fin = 0; n_rsp = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] || !req[i]) begin
                    if ($urandom_range(3) == 0) begin
                        a_in[i*10 +: 10] = 10'($urandom_range(1023));
                        d_in[i*5 +: 5]   = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                        req[i] = 1'b1;
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            tick;
        end
        req = '0;
        repeat (DIV_LAT + 6) tick;
        chk("traffic produced grants", n_gnt > 20, 1);
        chk("start count equals gnt count", n_start, n_gnt);
        chk("finish count equals gnt count", n_fin, n_gnt);
        chk("rsp count equals gnt count", n_rsp, n_gnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
